// File: rtl/game_table_lcd_reader_pkg.sv
// Shared constants and FSM encoding for the game table LCD reader.
// Holds the table geometry, the LCD geometry and the 2-bit state type.
package game_table_lcd_reader_pkg;

  localparam int GAME_COLS = 10;
  localparam int GAME_ROWS = 10;
  localparam int LCD_PAGES = 8;
  localparam int LCD_COLS  = 64;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_SEND = 2'd2,
    S_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/game_table_lcd_reader_lcd_page_byte_gen.sv
// Builds one 8-pixel LCD byte for a single column of the game table.
// Ports: col_bits (cell bit of each table row at this cell column),
// row_start/row_off (cell row and sub-pixel offset at page top),
// col_lit (column lies inside the board), data (bit b = pixel row b).
module lcd_page_byte_gen
  import game_table_lcd_reader_pkg::*;
#(
  parameter int CELL_PX = 6
) (
  input  logic [9:0] col_bits,
  input  logic [4:0] row_start,
  input  logic [2:0] row_off,
  input  logic       col_lit,
  output logic [7:0] data
);

  logic [4:0] r;
  logic [2:0] o;

  // Walk down the 8 pixel rows with a running (row, offset) pair
  // so no division by CELL_PX is needed.
  always_comb begin
    data = '0;
    r    = row_start;
    o    = row_off;
    for (int b = 0; b < 8; b++) begin
      if (col_lit && r < 5'(GAME_ROWS))
        data[b] = col_bits[r[3:0]];
      if (o == 3'(CELL_PX - 1)) begin
        o = '0;
        if (r != 5'(GAME_ROWS))
          r = r + 5'd1;
      end else begin
        o = o + 3'd1;
      end
    end
  end

endmodule

// File: rtl/game_table_lcd_reader.sv
// Renders the 10x10 game table into one 64-column half of the LCD.
// Ports: clk_40M, rst (async, high), game_table, frame_start in;
// lcd_valid/lcd_ready handshake with lcd_page/lcd_col/lcd_data,
// busy and frame_done status out.
// Optional: FRAME_SNAPSHOT_EN freezes the table at frame start.
module game_table_lcd_reader
  import game_table_lcd_reader_pkg::*;
#(
  parameter int CELL_PX = 6,
  parameter bit INVERT  = 1'b0
) (
  input  logic        clk_40M,
  input  logic        rst,
  input  logic [99:0] game_table,
  input  logic        frame_start,
  output logic        lcd_valid,
  input  logic        lcd_ready,
  output logic [2:0]  lcd_page,
  output logic [5:0]  lcd_col,
  output logic [7:0]  lcd_data,
  output logic        busy,
  output logic        frame_done
);

  // Cell rows crossed by one 8-pixel page step, split into
  // whole cells and leftover pixels (elaboration-time constants).
  localparam int PG_Q = 8 / CELL_PX;
  localparam int PG_R = 8 % CELL_PX;

  state_t      state, next;
  logic [2:0]  page;
  logic [5:0]  col;
  logic [3:0]  cell_col;
  logic [2:0]  col_off;
  logic [4:0]  page_row;
  logic [2:0]  page_off;
  logic [99:0] tbl;
  logic [9:0]  col_bits;
  logic [3:0]  cc;
  logic        col_lit;
  logic [7:0]  byte_val;
  logic        start;
  logic        accept;
  logic        last;
  logic [3:0]  off_sum;
  logic        off_wrap;
  logic [2:0]  next_off;
  logic [5:0]  row_sum;
  logic [4:0]  next_row;

  assign start  = (state == S_IDLE) && frame_start;
  assign accept = (state == S_SEND) && lcd_ready;
  assign last   = (page == 3'(LCD_PAGES - 1)) &&
                  (col == 6'(LCD_COLS - 1));

`ifdef FRAME_SNAPSHOT_EN
  logic [99:0] shadow;

  always_ff @(posedge clk_40M or posedge rst) begin
    if (rst)
      shadow <= '0;
    else if (start)
      shadow <= game_table;
  end

  assign tbl = shadow;
`else
  assign tbl = game_table;
`endif

  assign col_lit = cell_col < 4'(GAME_COLS);
  assign cc      = col_lit ? cell_col : 4'd0;

  always_comb begin
    col_bits = '0;
    for (int r = 0; r < GAME_ROWS; r++)
      col_bits[r] = tbl[7'(r * GAME_COLS) + 7'(cc)];
  end

  lcd_page_byte_gen #(
    .CELL_PX (CELL_PX)
  ) u_byte_gen (
    .col_bits  (col_bits),
    .row_start (page_row),
    .row_off   (page_off),
    .col_lit   (col_lit),
    .data      (byte_val)
  );

  // Cell row and offset at the top of the next page.
  always_comb begin
    off_sum  = {1'b0, page_off} + 4'(PG_R);
    off_wrap = off_sum >= 4'(CELL_PX);
    next_off = off_wrap ? 3'(off_sum - 4'(CELL_PX))
                        : off_sum[2:0];
    row_sum  = {1'b0, page_row} + 6'(PG_Q) +
               {5'b0, off_wrap};
    next_row = (row_sum > 6'(GAME_ROWS)) ? 5'(GAME_ROWS)
                                         : row_sum[4:0];
  end

  always_ff @(posedge clk_40M or posedge rst) begin
    if (rst)
      state <= S_IDLE;
    else
      state <= next;
  end

  always_comb begin
    next = state;
    unique case (state)
      S_IDLE: if (frame_start) next = S_LOAD;
      S_LOAD: next = S_SEND;
      S_SEND: if (lcd_ready) next = last ? S_DONE : S_LOAD;
      S_DONE: next = S_IDLE;
      default: next = S_IDLE;
    endcase
  end

  always_comb begin
    lcd_valid  = (state == S_SEND);
    busy       = (state == S_LOAD) || (state == S_SEND);
    frame_done = (state == S_DONE);
  end

  always_ff @(posedge clk_40M or posedge rst) begin
    if (rst) begin
      page     <= '0;
      col      <= '0;
      cell_col <= '0;
      col_off  <= '0;
      page_row <= '0;
      page_off <= '0;
      lcd_data <= '0;
    end else begin
      if (start) begin
        page     <= '0;
        col      <= '0;
        cell_col <= '0;
        col_off  <= '0;
        page_row <= '0;
        page_off <= '0;
      end
      if (state == S_LOAD)
        lcd_data <= INVERT ? ~byte_val : byte_val;
      if (accept && !last) begin
        if (col == 6'(LCD_COLS - 1)) begin
          col      <= '0;
          cell_col <= '0;
          col_off  <= '0;
          page     <= page + 3'd1;
          page_row <= next_row;
          page_off <= next_off;
        end else begin
          col <= col + 6'd1;
          if (col_off == 3'(CELL_PX - 1)) begin
            col_off <= '0;
            if (cell_col != 4'(GAME_COLS))
              cell_col <= cell_col + 4'd1;
          end else begin
            col_off <= col_off + 3'd1;
          end
        end
      end
    end
  end

  assign lcd_page = page;
  assign lcd_col  = col;

endmodule

// File: tb/tb_game_table_lcd_reader.sv
// Scoreboard bench for game_table_lcd_reader (default parameters).
// Expected bytes are queued per frame; a negedge monitor compares.
module tb_game_table_lcd_reader;

  localparam int CP = 6;

  logic        clk_40M = 1'b0;
  logic        rst = 1'b1;
  logic [99:0] game_table = '0;
  logic        frame_start = 1'b0;
  logic        lcd_ready = 1'b1;
  logic        lcd_valid;
  logic [2:0]  lcd_page;
  logic [5:0]  lcd_col;
  logic [7:0]  lcd_data;
  logic        busy;
  logic        frame_done;

  always #5 clk_40M = ~clk_40M;

  game_table_lcd_reader dut (
    .clk_40M     (clk_40M),
    .rst         (rst),
    .game_table  (game_table),
    .frame_start (frame_start),
    .lcd_valid   (lcd_valid),
    .lcd_ready   (lcd_ready),
    .lcd_page    (lcd_page),
    .lcd_col     (lcd_col),
    .lcd_data    (lcd_data),
    .busy        (busy),
    .frame_done  (frame_done)
  );

  typedef struct packed {
    logic [2:0] page;
    logic [5:0] col;
    logic [7:0] data;
  } xfer_t;

  xfer_t q[$];
  xfer_t prev;
  xfer_t got;
  bit    hold = 1'b0;
  int    n_chk = 0;
  int    n_fail = 0;
  int    n_acc = 0;
  int    fd_cnt = 0;
  int    base = 0;
  logic [99:0] ones = '1;
  logic [99:0] zero = '0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] exp_byte(input logic [99:0] t,
                                          input int page,
                                          input int col);
    logic [7:0] v;
    int y;
    int idx;
    v = '0;
    for (int b = 0; b < 8; b++) begin
      y = page * 8 + b;
      if (col < 10 * CP && y < 10 * CP) begin
        idx = (y / CP) * 10 + col / CP;
        v[b] = t[7'(idx)];
      end
    end
    return v;
  endfunction

  // Transfers with index < k use table a, the rest use table b.
  task automatic push_frame(input logic [99:0] a,
                            input logic [99:0] b,
                            input int k);
    xfer_t x;
    for (int i = 0; i < 512; i++) begin
      x.page = 3'(i / 64);
      x.col  = 6'(i % 64);
      x.data = exp_byte((i < k) ? a : b, i / 64, i % 64);
      q.push_back(x);
    end
  endtask

  always @(negedge clk_40M) begin
    if (hold)
      chk("hold", {14'b0, lcd_valid, lcd_page, lcd_col, lcd_data},
          {14'b0, 1'b1, prev});
    hold = lcd_valid && !lcd_ready;
    prev = {lcd_page, lcd_col, lcd_data};
    if (lcd_valid && lcd_ready) begin
      if (q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL xfer: unexpected page %0d col %0d data %0h",
                 lcd_page, lcd_col, lcd_data);
      end else begin
        got = q.pop_front();
        chk("xfer", {15'b0, lcd_page, lcd_col, lcd_data},
            {15'b0, got});
      end
      n_acc++;
    end
    if (frame_done)
      fd_cnt++;
  end

  task automatic start_frame();
    @(posedge clk_40M); #1 frame_start = 1'b1;
    @(posedge clk_40M); #1 frame_start = 1'b0;
  endtask

  task automatic wait_acc(input int target);
    int t;
    t = 0;
    while (n_acc < target && t < 4000) begin
      @(posedge clk_40M);
      t++;
    end
    chk("wait_acc reached", 32'(n_acc >= target), 32'd1);
  endtask

  task automatic wait_done(input int n, input int b);
    int t;
    t = 0;
    while (fd_cnt < n && t < 4000) begin
      @(posedge clk_40M);
      t++;
    end
    repeat (3) @(negedge clk_40M);
    chk("frame_done count", 32'(fd_cnt), 32'(n));
    chk("xfer count", 32'(n_acc - b), 32'd512);
    chk("busy after done", {31'b0, busy}, 32'd0);
    chk("queue empty", 32'(q.size()), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk_40M);
    @(negedge clk_40M);
    chk("reset valid", {31'b0, lcd_valid}, 32'd0);
    chk("reset page", {29'b0, lcd_page}, 32'd0);
    chk("reset col", {26'b0, lcd_col}, 32'd0);
    chk("reset data", {24'b0, lcd_data}, 32'd0);
    chk("reset busy", {31'b0, busy}, 32'd0);
    chk("reset done", {31'b0, frame_done}, 32'd0);
    @(posedge clk_40M); #1 rst = 1'b0;

    // Single cell at row 0 col 0, with first-valid latency check.
    game_table = '0;
    game_table[0] = 1'b1;
    base = n_acc;
    push_frame(game_table, game_table, 512);
    start_frame();
    @(negedge clk_40M);
    chk("load busy", {31'b0, busy}, 32'd1);
    chk("load valid", {31'b0, lcd_valid}, 32'd0);
    @(negedge clk_40M);
    chk("first valid", {31'b0, lcd_valid}, 32'd1);
    wait_done(1, base);

    // Row 1 col 0 straddles pages 0 and 1.
    game_table = '0;
    game_table[10] = 1'b1;
    base = n_acc;
    push_frame(game_table, game_table, 512);
    start_frame();
    wait_done(2, base);

    // Bottom-right cell.
    game_table = '0;
    game_table[99] = 1'b1;
    base = n_acc;
    push_frame(game_table, game_table, 512);
    start_frame();
    wait_done(3, base);

    // Full table with a 5-cycle stall on the third transfer.
    game_table = ones;
    base = n_acc;
    push_frame(game_table, game_table, 512);
    start_frame();
    wait_acc(base + 2);
    #1 lcd_ready = 1'b0;
    repeat (6) @(posedge clk_40M);
    #1 lcd_ready = 1'b1;
    wait_done(4, base);

    // frame_start while busy must be ignored.
    game_table = '0;
    game_table[99] = 1'b1;
    base = n_acc;
    push_frame(game_table, game_table, 512);
    start_frame();
    wait_acc(base + 200);
    #1 frame_start = 1'b1;
    @(posedge clk_40M); #1 frame_start = 1'b0;
    wait_done(5, base);

    // Reset in the middle of a frame.
    game_table = ones;
    base = n_acc;
    push_frame(game_table, game_table, 512);
    start_frame();
    wait_acc(base + 100);
    #1 rst = 1'b1;
    @(negedge clk_40M);
    chk("midrst valid", {31'b0, lcd_valid}, 32'd0);
    chk("midrst page", {29'b0, lcd_page}, 32'd0);
    chk("midrst col", {26'b0, lcd_col}, 32'd0);
    chk("midrst data", {24'b0, lcd_data}, 32'd0);
    chk("midrst busy", {31'b0, busy}, 32'd0);
    chk("midrst done", {31'b0, frame_done}, 32'd0);
    repeat (2) @(posedge clk_40M);
    #1 rst = 1'b0;
    q.delete();
    repeat (5) @(negedge clk_40M);
    chk("no done after rst", 32'(fd_cnt), 32'd5);
    chk("idle after rst", {31'b0, busy}, 32'd0);

    // Table changes after transfer 10 of the frame.
    game_table = '0;
    base = n_acc;
`ifdef FRAME_SNAPSHOT_EN
    push_frame(zero, zero, 512);
`else
    push_frame(zero, ones, 11);
`endif
    start_frame();
    wait_acc(base + 11);
    #1 game_table = ones;
    wait_done(6, base);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
